// File: rtl/pulse_gen_arbiter_if.sv
// Bundle between the requesting control blocks, the round-robin arbiter and one shared pulse_gen.
// The slave side is the arbiter; the master side is everything around it.
interface pulse_gen_arbiter_if #(
    parameter int REQ_NUM     = 4,
    parameter int CNTR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8
);
    logic [REQ_NUM-1:0]             req;
    logic [REQ_NUM*CNTR_WIDTH-1:0]  req_cntr_max;
    logic [REQ_NUM*CNTR_WIDTH-1:0]  req_cntr_low;
    logic [REQ_NUM*BURST_WIDTH-1:0] req_burst;
    logic [REQ_NUM-1:0]             grant;
    logic [REQ_NUM-1:0]             ack;
    logic                           err;
    logic                           ctrl_busy;
    logic                           pg_start;
    logic [CNTR_WIDTH-1:0]          pg_cntr_max;
    logic [CNTR_WIDTH-1:0]          pg_cntr_low;
    logic                           pg_start_strobe;
    logic                           pg_busy;

    modport slave (
        input  req, req_cntr_max, req_cntr_low, req_burst, pg_start_strobe, pg_busy,
        output grant, ack, err, ctrl_busy, pg_start, pg_cntr_max, pg_cntr_low
    );

    modport master (
        output req, req_cntr_max, req_cntr_low, req_burst, pg_start_strobe, pg_busy,
        input  grant, ack, err, ctrl_busy, pg_start, pg_cntr_max, pg_cntr_low
    );
endinterface

// File: rtl/pulse_gen_arbiter.sv
// Round-robin scheduler sharing one pulse_gen between REQ_NUM requesters; each grant runs
// a burst of pulses with the winner's latched period/low settings, then acknowledges it.
module pulse_gen_arbiter #(
    parameter int REQ_NUM     = 4,
    parameter int CNTR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_gen_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(REQ_NUM);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 r_state;
    logic [REQ_NUM-1:0]     r_grant;
    logic [REQ_NUM-1:0]     r_ack;
    logic                   r_err;
    logic                   r_busy;
    logic                   r_pg_start;
    logic [CNTR_WIDTH-1:0]  r_cntr_max;
    logic [CNTR_WIDTH-1:0]  r_cntr_low;
    logic [BURST_WIDTH-1:0] r_burst_left;
    logic [IDX_W-1:0]       r_last;

    logic [IDX_W-1:0]       w_cand [REQ_NUM];
    logic [CNTR_WIDTH-1:0]  w_cmax_arr [REQ_NUM];
    logic [CNTR_WIDTH-1:0]  w_clow_arr [REQ_NUM];
    logic [BURST_WIDTH-1:0] w_burst_arr [REQ_NUM];
    logic [IDX_W-1:0]       w_win;
    logic [REQ_NUM-1:0]     w_win_oh;
    logic [CNTR_WIDTH-1:0]  w_cmax;
    logic [BURST_WIDTH-1:0] w_burst;

    // w_cand[gi] is the requester index at search distance gi from last+1, wrapped mod REQ_NUM.
    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum         = {1'b0, r_last} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi]    = (w_sum >= (IDX_W+1)'(REQ_NUM)) ?
                                   IDX_W'(w_sum - (IDX_W+1)'(REQ_NUM)) : w_sum[IDX_W-1:0];
            assign w_cmax_arr[gi]  = bus.req_cntr_max[gi*CNTR_WIDTH +: CNTR_WIDTH];
            assign w_clow_arr[gi]  = bus.req_cntr_low[gi*CNTR_WIDTH +: CNTR_WIDTH];
            assign w_burst_arr[gi] = bus.req_burst[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest requesting one wins.
    always_comb begin
        w_win = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (bus.req[w_cand[k]]) begin
                w_win = w_cand[k];
            end
        end
    end

    assign w_win_oh = REQ_NUM'(1) << w_win;
    assign w_cmax   = w_cmax_arr[w_win];
    assign w_burst  = w_burst_arr[w_win];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_pg_start   <= 1'b0;
            r_cntr_max   <= '0;
            r_cntr_low   <= '0;
            r_burst_left <= '0;
            r_last       <= IDX_W'(REQ_NUM - 1);
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_grant      <= w_win_oh;
                        r_last       <= w_win;
                        r_cntr_max   <= w_cmax;
                        r_cntr_low   <= w_clow_arr[w_win];
                        r_burst_left <= w_burst;
                        r_busy       <= 1'b1;
                        if (w_cmax == '0) begin
                            r_err   <= 1'b1;
                            r_ack   <= w_win_oh;
                            r_state <= DONE;
                        end else if (w_burst == '0) begin
                            r_ack   <= w_win_oh;
                            r_state <= DONE;
                        end else begin
                            r_pg_start <= 1'b1;
                            r_state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.pg_start_strobe) begin
                        r_burst_left <= r_burst_left - 1'b1;
                        if (r_burst_left == BURST_WIDTH'(1)) begin
                            r_pg_start <= 1'b0;
                            r_state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.pg_busy) begin
                        r_ack   <= r_grant;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.ack         = r_ack;
    assign bus.err         = r_err;
    assign bus.ctrl_busy   = r_busy;
    assign bus.pg_start    = r_pg_start;
    assign bus.pg_cntr_max = r_cntr_max;
    assign bus.pg_cntr_low = r_cntr_low;
endmodule

// File: tb/tb_pulse_gen_arbiter.sv
// Bench for pulse_gen_arbiter: behavioural pulse_gen model, table of single requests,
// hand-written round-robin / mid-burst / reset / spurious-strobe sequences, scoreboard on ack.
module tb_pulse_gen_arbiter;
    localparam int N  = 4;
    localparam int CW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_gen_arbiter_if #(.REQ_NUM(N), .CNTR_WIDTH(CW), .BURST_WIDTH(BW)) bus ();

    pulse_gen_arbiter #(.REQ_NUM(N), .CNTR_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Generator model: one strobe per period of cntr_max+1 cycles, re-samples start at period end.
    logic          m_busy, m_strobe, inj_strobe;
    logic [CW-1:0] m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_strobe <= 1'b0;
            m_cnt    <= '0;
        end else begin
            m_strobe <= 1'b0;
            if (!m_busy) begin
                if (bus.pg_start) begin
                    m_busy   <= 1'b1;
                    m_cnt    <= '0;
                    m_strobe <= 1'b1;
                end
            end else if (m_cnt == bus.pg_cntr_max) begin
                if (bus.pg_start) begin
                    m_cnt    <= '0;
                    m_strobe <= 1'b1;
                end else begin
                    m_busy <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 1'b1;
            end
        end
    end
    assign bus.pg_start_strobe = m_strobe | inj_strobe;
    assign bus.pg_busy         = m_busy;

    typedef struct {
        int            idx;
        logic [CW-1:0] cmax;
        logic [CW-1:0] clow;
        logic [BW-1:0] burst;
        logic [N-1:0]  exp_ack;
        int            exp_pulses;
        int            exp_lat;
        int            exp_busy;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [N-1:0]  ack;
        int            pulses;
        int            lat;
        int            busy;
        logic          err;
        logic [CW-1:0] cmax;
        logic [CW-1:0] clow;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[6];
    int   errors = 0;
    int   checks = 0;
    int   viol   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int idx, input logic [CW-1:0] m, input logic [CW-1:0] l,
                                    input logic [BW-1:0] b);
        exp_t e;
        e.ack  = N'(1) << idx;
        e.err  = (m == 0);
        e.cmax = m;
        e.clow = l;
        if (m == 0 || b == 0) begin
            e.pulses = 0;
            e.lat    = 0;
            e.busy   = 0;
        end else begin
            e.pulses = int'(b);
            e.busy   = int'(b) * (int'(m) + 1);
            e.lat    = e.busy + 2;
        end
        return e;
    endfunction

    task automatic set_cfg(input int i, input logic [CW-1:0] m, input logic [CW-1:0] l,
                           input logic [BW-1:0] b);
        bus.req_cntr_max[i*CW +: CW] = m;
        bus.req_cntr_low[i*CW +: CW] = l;
        bus.req_burst[i*BW +: BW]    = b;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.ack != '0 || n >= budget) break;
        end
        if (bus.ack == '0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack within %0d cycles, required one", name, budget);
        end
    endtask

    // Monitor: per-grant accounting, popped against the scoreboard when ack appears.
    int   mon_strobes, mon_lat, mon_busy;
    logic mon_start_seen, mon_in;
    always @(negedge clk) begin
        if (rst) begin
            mon_in = 1'b0;
        end else begin
            if ($countones(bus.grant) > 1) viol++;
            if (bus.pg_start && bus.grant == '0) viol++;
            if (bus.ack != '0 && bus.ack !== bus.grant) viol++;
            if (bus.err && bus.ack == '0) viol++;
            if (bus.grant != '0) begin
                if (!mon_in) begin
                    mon_in         = 1'b1;
                    mon_strobes    = 0;
                    mon_lat        = 0;
                    mon_busy       = 0;
                    mon_start_seen = 1'b0;
                end
                if (bus.pg_start_strobe) mon_strobes++;
                if (bus.pg_busy) mon_busy++;
                if (bus.pg_start) mon_start_seen = 1'b1;
                if (bus.ack != '0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got ack=%b, required none", bus.ack);
                    end else begin
                        mon_e = sb.pop_front();
                        check("ack",       64'(bus.ack),         64'(mon_e.ack));
                        check("grant",     64'(bus.grant),       64'(mon_e.ack));
                        check("pulses",    64'(mon_strobes),     64'(mon_e.pulses));
                        check("latency",   64'(mon_lat),         64'(mon_e.lat));
                        check("busy_cyc",  64'(mon_busy),        64'(mon_e.busy));
                        check("err",       64'(bus.err),         64'(mon_e.err));
                        check("cntr_max",  64'(bus.pg_cntr_max), 64'(mon_e.cmax));
                        check("cntr_low",  64'(bus.pg_cntr_low), 64'(mon_e.clow));
                        check("start_seen", 64'(mon_start_seen), 64'(mon_e.pulses > 0));
                        check("ctrl_busy", 64'(bus.ctrl_busy),   64'(1));
                        $display("txn ack=%b pulses=%0d lat=%0d busy=%0d err=%b cmax=%0d",
                                 bus.ack, mon_strobes, mon_lat, mon_busy, bus.err, bus.pg_cntr_max);
                    end
                end else begin
                    mon_lat++;
                end
            end else begin
                mon_in = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        inj_strobe = 1'b0;
        bus.req          = '0;
        bus.req_cntr_max = '0;
        bus.req_cntr_low = '0;
        bus.req_burst    = '0;

        tbl[0] = '{0, 32'd4, 32'd2, 8'd3, 4'b0001, 3, 17, 15, 1'b0};
        tbl[1] = '{2, 32'd3, 32'd1, 8'd0, 4'b0100, 0,  0,  0, 1'b0};
        tbl[2] = '{1, 32'd0, 32'd0, 8'd5, 4'b0010, 0,  0,  0, 1'b1};
        tbl[3] = '{3, 32'd1, 32'd1, 8'd4, 4'b1000, 4, 10,  8, 1'b0};
        tbl[4] = '{0, 32'd7, 32'd3, 8'd2, 4'b0001, 2, 18, 16, 1'b0};
        tbl[5] = '{1, 32'd2, 32'd0, 8'd6, 4'b0010, 6, 20, 18, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant",     64'(bus.grant),       64'(0));
        check("rst_ack",       64'(bus.ack),         64'(0));
        check("rst_err",       64'(bus.err),         64'(0));
        check("rst_ctrl_busy", 64'(bus.ctrl_busy),   64'(0));
        check("rst_pg_start",  64'(bus.pg_start),    64'(0));
        check("rst_cntr_max",  64'(bus.pg_cntr_max), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_grant", 64'(bus.grant), 64'(0));

        // Round robin with all four requesting
        for (int i = 0; i < N; i++) set_cfg(i, 32'd2, 32'd1, 8'd1);
        for (int k = 0; k < 6; k++) sb.push_back(mk_exp(k % N, 32'd2, 32'd1, 8'd1));
        bus.req = 4'b1111;
        for (int k = 0; k < 6; k++) wait_ack("rr", 100);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Table of single requests
        for (int v = 0; v < 6; v++) begin
            exp_t e;
            set_cfg(tbl[v].idx, tbl[v].cmax, tbl[v].clow, tbl[v].burst);
            e.ack    = tbl[v].exp_ack;
            e.pulses = tbl[v].exp_pulses;
            e.lat    = tbl[v].exp_lat;
            e.busy   = tbl[v].exp_busy;
            e.err    = tbl[v].exp_err;
            e.cmax   = tbl[v].cmax;
            e.clow   = tbl[v].clow;
            sb.push_back(e);
            bus.req = N'(1) << tbl[v].idx;
            wait_ack("table", 1000);
            bus.req = '0;
            repeat (2) @(negedge clk);
        end

        // Settings change and dropped request mid-burst
        set_cfg(0, 32'd4, 32'd2, 8'd3);
        sb.push_back(mk_exp(0, 32'd4, 32'd2, 8'd3));
        bus.req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pg_start_strobe && n < 50);
        check("mid_strobe_seen", 64'(bus.pg_start_strobe), 64'(1));
        bus.req_cntr_max[0 +: CW] = 32'd9;
        bus.req = '0;
        wait_ack("midburst", 200);
        repeat (2) @(negedge clk);

        // Spurious strobe in IDLE, then a 2-pulse burst
        inj_strobe = 1'b1;
        @(negedge clk);
        inj_strobe = 1'b0;
        repeat (2) @(negedge clk);
        set_cfg(2, 32'd3, 32'd1, 8'd2);
        sb.push_back(mk_exp(2, 32'd3, 32'd1, 8'd2));
        bus.req = 4'b0100;
        wait_ack("spurious", 200);
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Reset in RUN with two pulses left
        set_cfg(0, 32'd4, 32'd2, 8'd3);
        bus.req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pg_start_strobe && n < 50);
        @(posedge clk);
        #2;
        check("pre_rst_pg_start", 64'(bus.pg_start), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_grant",     64'(bus.grant),       64'(0));
        check("mid_rst_ack",       64'(bus.ack),         64'(0));
        check("mid_rst_err",       64'(bus.err),         64'(0));
        check("mid_rst_ctrl_busy", 64'(bus.ctrl_busy),   64'(0));
        check("mid_rst_pg_start",  64'(bus.pg_start),    64'(0));
        check("mid_rst_cntr_max",  64'(bus.pg_cntr_max), 64'(0));
        check("mid_rst_cntr_low",  64'(bus.pg_cntr_low), 64'(0));
        set_cfg(1, 32'd1, 32'd0, 8'd2);
        set_cfg(3, 32'd2, 32'd1, 8'd1);
        sb.push_back(mk_exp(1, 32'd1, 32'd0, 8'd2));
        sb.push_back(mk_exp(3, 32'd2, 32'd1, 8'd1));
        bus.req = 4'b1010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ack("post_rst_first", 100);
        bus.req = 4'b1000;
        wait_ack("post_rst_second", 100);
        bus.req = '0;
        repeat (3) @(negedge clk);

        check("sb_drained", 64'(sb.size()), 64'(0));
        check("invariants", 64'(viol),      64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
